// File: rtl/tvout_pkg.sv
// Shared constants and types for the video RAM arbiter and its fill sequencer.
package tvout_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 512 * 288 / 8;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    HOLD    = 2'd2
  } host_state_e;

  // True when the byte address maps onto a real RAM location.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a < ADDR_W'(DEPTH));
  endfunction

endpackage

// File: rtl/vram_fill_seq.sv
// Whole-frame fill engine: walks every RAM byte once, one write per grant.
module vram_fill_seq
  import tvout_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_grant,
  output logic              o_pending,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_busy,
  output logic              o_done
);

  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_value;

  // Start only from idle (a start while busy neither restarts nor relatches);
  // advance on each grant and finish after the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_value <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy  <= 1'b1;
          r_addr  <= '0;
          r_value <= i_value;
        end
      end else if (i_grant) begin
        if (r_addr == LAST_ADDR) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_addr <= '0;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  assign o_pending = r_busy;
  assign o_addr    = r_addr;
  assign o_wdata   = r_value;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display fetch has absolute priority,
// host port and fill sequencer share the remaining cycles round-robin.
//
// Host FSM states:
//   state   | meaning
//   IDLE    | host eligible for a grant
//   GRANTED | access issued last cycle; ack (and read data) presented now
//   HOLD    | one dead cycle so a still-high req is not regranted
module vram_arbiter
  import tvout_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_strobe,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              w_fill_pending;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [DATA_W-1:0] w_fill_wdata;
  logic              w_fetch_gnt;
  logic              w_host_elig;
  logic              w_host_gnt;
  logic              w_fill_gnt;
  logic              w_fetch_in;
  logic              w_host_in;

  host_state_e       r_state;
  logic              r_rr_host;
  logic              r_fetch_valid;
  logic              r_fetch_rd;
  logic              r_host_ack;
  logic              r_host_rd;

  assign w_fetch_in = in_range(fetch_addr);
  assign w_host_in  = in_range(host_addr);

  // Grant decision; gated by rst_n so nothing reaches the RAM while in reset.
  // r_rr_host means host wins the next host-vs-fill tie.
  always_comb begin
    w_fetch_gnt = rst_n & fetch_strobe;
    w_host_elig = rst_n & host_req & (r_state == IDLE);
    w_host_gnt  = ~w_fetch_gnt & w_host_elig & (~w_fill_pending | r_rr_host);
    w_fill_gnt  = ~w_fetch_gnt & w_fill_pending & (~w_host_elig | ~r_rr_host);
  end

  // Drive the RAM port from whichever requester owns this cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_fetch_gnt) begin
      if (w_fetch_in) begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
      end
    end else if (w_host_gnt) begin
      if (w_host_in) begin
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_we ? host_wdata : '0;
      end
    end else if (w_fill_gnt) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = w_fill_addr;
      mem_wdata = w_fill_wdata;
    end
  end

  // Fetch return tracking: always pulse valid, only pass RAM data when it was read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_valid <= 1'b0;
      r_fetch_rd    <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch_gnt;
      r_fetch_rd    <= w_fetch_gnt & w_fetch_in;
    end
  end

  // Round-robin pointer follows the last host or fill winner, contested or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_host <= 1'b1;
    end else if (w_host_gnt) begin
      r_rr_host <= 1'b0;
    end else if (w_fill_gnt) begin
      r_rr_host <= 1'b1;
    end
  end

  // Host access FSM with registered ack and read-data select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_host_ack <= 1'b0;
      r_host_rd  <= 1'b0;
    end else begin
      r_host_ack <= 1'b0;
      r_host_rd  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_host_gnt) begin
            r_state    <= GRANTED;
            r_host_ack <= 1'b1;
            r_host_rd  <= ~host_we & w_host_in;
          end
        end
        GRANTED: r_state <= HOLD;
        HOLD:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign fetch_data  = r_fetch_rd ? mem_rdata : '0;
  assign host_ack    = r_host_ack;
  assign host_rdata  = r_host_rd ? mem_rdata : '0;

  vram_fill_seq u_fill (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (fill_start),
    .i_value   (fill_value),
    .i_grant   (w_fill_gnt),
    .o_pending (w_fill_pending),
    .o_addr    (w_fill_addr),
    .o_wdata   (w_fill_wdata),
    .o_busy    (fill_busy),
    .o_done    (fill_done)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM, shadow-memory reference model,
// directed scenarios followed by a randomized fetch/host traffic phase.
module tb_vram_arbiter;

  localparam int D = 18432;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_strobe;
  logic [14:0] fetch_addr;
  logic [7:0]  fetch_data;
  logic        fetch_valid;
  logic        host_req;
  logic        host_we;
  logic [14:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        fill_start;
  logic [7:0]  fill_value;
  logic        fill_busy;
  logic        fill_done;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram    [0:D-1];
  logic [7:0]  shadow [0:D-1];
  int          oor_hits;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_strobe(fetch_strobe), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_byte(input int i);
    if (i == 32'h2001) return 8'hAA;
    return 8'(i ^ (i >> 7) ^ 32'h5A);
  endfunction

  // Synchronous single-port RAM; reloads its known pattern while reset is low.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) ram[i] <= init_byte(i);
      mem_rdata <= 8'h00;
      oor_hits  <= 0;
    end else if (mem_en) begin
      if (int'(mem_addr) >= D) oor_hits <= oor_hits + 1;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] pick_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 15'(32'h4800 + $urandom_range(0, 32'h37FF));
    if (r == 1) return 15'($urandom_range(0, D - 1));
    return 15'(32'h2000 + $urandom_range(0, 63));
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, bad;
    logic        h_act, e_fv, e_ack, exp_en;
    logic [7:0]  e_fd, e_rd;
    int          gap;

    rst_n = 1'b0;
    fetch_strobe = 1'b0; fetch_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    fill_start = 1'b0; fill_value = '0;
    for (int i = 0; i < D; i++) shadow[i] = init_byte(i);

    // ---- reset state
    repeat (3) tick();
    #1;
    chk("reset_out_a", 32'({fetch_valid, fetch_data, host_ack, host_rdata, fill_busy, fill_done}), 32'h0);
    chk("reset_out_b", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'h0);
    tick(); rst_n = 1'b1; #1;
    chk("post_reset_busy", 32'(fill_busy), 32'h0);

    // ---- fetch only, strobe every 8 cycles
    for (int k = 0; k < 3; k++) begin
      tick(); fetch_strobe = 1'b1; fetch_addr = 15'h2001; #1;
      chk("fetch_mem_en", 32'(mem_en), 32'h1);
      chk("fetch_mem_we", 32'(mem_we), 32'h0);
      chk("fetch_mem_addr", 32'(mem_addr), 32'h2001);
      tick(); fetch_strobe = 1'b0; #1;
      chk("fetch_valid", 32'(fetch_valid), 32'h1);
      chk("fetch_data", 32'(fetch_data), 32'hAA);
      repeat (6) begin tick(); #1; chk("fetch_idle_valid", 32'(fetch_valid), 32'h0); end
    end

    // ---- host write then read
    tick(); host_req = 1'b1; host_we = 1'b1; host_addr = 15'h2042; host_wdata = 8'hA0; #1;
    chk("hw_mem_en", 32'(mem_en), 32'h1);
    chk("hw_mem_we", 32'(mem_we), 32'h1);
    chk("hw_mem_addr", 32'(mem_addr), 32'h2042);
    chk("hw_mem_wdata", 32'(mem_wdata), 32'hA0);
    chk("hw_no_early_ack", 32'(host_ack), 32'h0);
    tick(); host_req = 1'b0; #1;
    chk("hw_ack", 32'(host_ack), 32'h1);
    shadow[15'h2042] = 8'hA0;
    tick(); #1;
    chk("hw_hold_no_ack", 32'(host_ack), 32'h0);
    tick(); host_req = 1'b1; host_we = 1'b0; host_addr = 15'h2042; #1;
    chk("hr_mem_en", 32'(mem_en), 32'h1);
    chk("hr_mem_we", 32'(mem_we), 32'h0);
    tick(); host_req = 1'b0; #1;
    chk("hr_ack", 32'(host_ack), 32'h1);
    chk("hr_rdata", 32'(host_rdata), 32'hA0);
    tick(); #1;

    // ---- fetch/host conflict
    tick(); fetch_strobe = 1'b1; fetch_addr = 15'h0010;
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h2042; #1;
    chk("cf_fetch_first", 32'(mem_addr), 32'h0010);
    tick(); fetch_strobe = 1'b0; #1;
    chk("cf_fetch_valid", 32'(fetch_valid), 32'h1);
    chk("cf_fetch_data", 32'(fetch_data), 32'(init_byte(32'h10)));
    chk("cf_no_ack_yet", 32'(host_ack), 32'h0);
    chk("cf_host_next", 32'({mem_en, mem_addr}), 32'({1'b1, 15'h2042}));
    tick(); host_req = 1'b0; #1;
    chk("cf_ack", 32'(host_ack), 32'h1);
    chk("cf_rdata", 32'(host_rdata), 32'hA0);
    tick(); #1;

    // ---- out-of-range host read/write and fetch
    tick(); host_req = 1'b1; host_we = 1'b0; host_addr = 15'h4800; #1;
    chk("oor_hr_mem_en", 32'(mem_en), 32'h0);
    tick(); host_req = 1'b0; #1;
    chk("oor_hr_ack", 32'(host_ack), 32'h1);
    chk("oor_hr_rdata", 32'(host_rdata), 32'h0);
    tick(); #1;
    tick(); host_req = 1'b1; host_we = 1'b1; host_addr = 15'h4800; host_wdata = 8'h55; #1;
    chk("oor_hw_mem_en", 32'(mem_en), 32'h0);
    tick(); host_req = 1'b0; #1;
    chk("oor_hw_ack", 32'(host_ack), 32'h1);
    tick(); #1;
    tick(); fetch_strobe = 1'b1; fetch_addr = 15'h4800; #1;
    chk("oor_f_mem_en", 32'(mem_en), 32'h0);
    tick(); fetch_strobe = 1'b0; #1;
    chk("oor_f_valid", 32'(fetch_valid), 32'h1);
    chk("oor_f_data", 32'(fetch_data), 32'h0);

    // ---- full fill with 0x00, ignored restart mid-fill
    tick(); fill_start = 1'b1; fill_value = 8'h00; #1;
    tick(); fill_start = 1'b0; #1;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 20000; c++) begin
      if (fill_busy) busy_cnt++;
      if (fill_done) done_cnt++;
      if (c == 0) chk("fill_first_addr", 32'({mem_en, mem_we, mem_addr}), 32'({2'b11, 15'h0}));
      if (c == 5) chk("fill_addr5", 32'(mem_addr), 32'h5);
      if (c == 105) chk("fill_value_kept", 32'({mem_en, mem_wdata}), 32'({1'b1, 8'h00}));
      if (!fill_busy && busy_cnt > 0) break;
      tick();
      if (c == 99) begin fill_start = 1'b1; fill_value = 8'hFF; end
      else fill_start = 1'b0;
      #1;
    end
    repeat (3) begin tick(); #1; if (fill_done) done_cnt++; end
    chk("fill_busy_cycles", 32'(busy_cnt), 32'(D));
    chk("fill_done_pulses", 32'(done_cnt), 32'h1);
    bad = 0;
    for (int i = 0; i < D; i++) if (ram[i] !== 8'h00) bad++;
    chk("fill_ram_zero", 32'(bad), 32'h0);
    for (int i = 0; i < D; i++) shadow[i] = 8'h00;

    // ---- round-robin between held host request and fill
    tick(); fill_start = 1'b1; fill_value = 8'h3C; #1;
    tick(); fill_start = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 15'h2100; #1;
    for (int c = 0; c < 12; c++) begin
      chk("rr_host_wins", 32'(mem_en && !mem_we && mem_addr == 15'h2100), 32'(c % 3 == 0));
      chk("rr_ack", 32'(host_ack), 32'(c % 3 == 1));
      if (c % 3 == 1) chk("rr_rdata", 32'(host_rdata), 32'h0);
      tick(); #1;
    end
    tick(); host_req = 1'b0; #1;
    done_cnt = 0;
    for (int c = 0; c < 20000; c++) begin
      tick(); #1;
      if (fill_done) done_cnt++;
      if (!fill_busy) break;
    end
    chk("rr_fill_done", 32'(done_cnt), 32'h1);
    bad = 0;
    for (int i = 0; i < D; i++) if (ram[i] !== 8'h3C) bad++;
    chk("rr_ram_3c", 32'(bad), 32'h0);
    for (int i = 0; i < D; i++) shadow[i] = 8'h3C;

    // ---- randomized fetch + host traffic against the shadow model
    h_act = 1'b0; gap = 0; e_fv = 1'b0; e_fd = '0; e_ack = 1'b0; e_rd = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      fetch_strobe = ($urandom_range(0, 2) == 0);
      fetch_addr   = pick_addr();
      if (!h_act) begin
        if (gap == 0) begin
          h_act = 1'b1;
          host_we = 1'($urandom_range(0, 1));
          host_addr = pick_addr();
          host_wdata = 8'($urandom);
        end else gap--;
      end
      host_req = h_act;
      #1;
      chk("rnd_fetch_valid", 32'(fetch_valid), 32'(e_fv));
      if (e_fv) chk("rnd_fetch_data", 32'(fetch_data), 32'(e_fd));
      chk("rnd_host_ack", 32'(host_ack), 32'(e_ack));
      if (e_ack) chk("rnd_host_rdata", 32'(host_rdata), 32'(e_rd));
      e_fv = fetch_strobe;
      e_fd = (fetch_strobe && int'(fetch_addr) < D) ? shadow[fetch_addr] : 8'h00;
      exp_en = fetch_strobe && int'(fetch_addr) < D;
      e_ack = 1'b0; e_rd = 8'h00;
      if (h_act && !fetch_strobe) begin
        e_ack = 1'b1;
        exp_en = int'(host_addr) < D;
        if (int'(host_addr) < D) begin
          if (host_we) shadow[host_addr] = host_wdata;
          else e_rd = shadow[host_addr];
        end
        h_act = 1'b0;
        gap = 2 + $urandom_range(0, 2);
      end
      chk("rnd_mem_en", 32'(mem_en), 32'(exp_en));
    end
    tick(); fetch_strobe = 1'b0; host_req = 1'b0; #1;
    repeat (3) tick();
    chk("no_oor_ram_access", 32'(oor_hits), 32'h0);

    // ---- asynchronous reset in the middle of a fill
    tick(); fill_start = 1'b1; fill_value = 8'h11; #1;
    tick(); fill_start = 1'b0; #1;
    repeat (40) tick();
    fetch_strobe = 1'b1; fetch_addr = 15'h2001;
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h2042; #1;
    chk("rst_pre_busy", 32'(fill_busy), 32'h1);
    rst_n = 1'b0; #1;
    chk("rst_busy_clear", 32'(fill_busy), 32'h0);
    chk("rst_out_a", 32'({fetch_valid, fetch_data, host_ack, host_rdata, fill_done}), 32'h0);
    chk("rst_out_b", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'h0);
    fetch_strobe = 1'b0; host_req = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(); #1;
      chk("rst_after", 32'({fetch_valid, host_ack, fill_done, fill_busy}), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
